// File: rtl/signed_seq_divider.sv
// rtl/signed_seq_divider.sv - restoring radix-2 sequential divider, signed or unsigned operands
// Define DIVZERO_FAST_EN to short-cut divide-by-zero (IDLE->FIX, dbz flag); default runs it full length.
module signed_seq_divider #(
   parameter int WIDTH       = 16,
   parameter int SIGNED_MODE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dbz
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   b_mag;
   logic [WIDTH-1:0] q_sh;
   logic             a_neg;
   logic             b_neg;

   logic             a_neg_in;
   logic             b_neg_in;
   logic [WIDTH-1:0] a_mag_in;
   logic [WIDTH:0]   b_mag_in;
   logic [WIDTH+1:0] trial;
   logic [WIDTH+1:0] diff;
   logic             ge;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

`ifdef DIVZERO_FAST_EN
   logic             zero;
`endif

   always_comb begin
      a_neg_in = (SIGNED_MODE != 0) && dividend[WIDTH-1];
      b_neg_in = (SIGNED_MODE != 0) && divisor[WIDTH-1];
      // the most-negative dividend magnitude still fits WIDTH bits as unsigned
      a_mag_in = a_neg_in ? -dividend : dividend;
      b_mag_in = b_neg_in ? -{1'b1, divisor} : {1'b0, divisor};
      trial    = {rem, q_sh[WIDTH-1]};
      diff     = trial - {1'b0, b_mag};
      ge       = ~diff[WIDTH+1];
      rem_fix  = a_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
      quo_fix  = (a_neg ^ b_neg) ? -q_sh : q_sh;
`ifdef DIVZERO_FAST_EN
      if (zero) begin
         quo_fix = '1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         cnt       <= '0;
         rem       <= '0;
         b_mag     <= '0;
         q_sh      <= '0;
         a_neg     <= 1'b0;
         b_neg     <= 1'b0;
`ifdef DIVZERO_FAST_EN
         dbz       <= 1'b0;
         zero      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_neg <= a_neg_in;
                  b_neg <= b_neg_in;
                  b_mag <= b_mag_in;
                  q_sh  <= a_mag_in;
                  rem   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
`ifdef DIVZERO_FAST_EN
                  if (divisor == '0) begin
                     rem   <= {1'b0, a_mag_in};
                     q_sh  <= '1;
                     zero  <= 1'b1;
                     state <= FIX;
                  end else begin
                     zero  <= 1'b0;
                     state <= CALC;
                  end
`else
                  state <= CALC;
`endif
               end
            end
            CALC: begin
               rem  <= ge ? diff[WIDTH:0] : trial[WIDTH:0];
               q_sh <= {q_sh[WIDTH-2:0], ge};
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               quotient  <= quo_fix;
               remainder <= rem_fix;
`ifdef DIVZERO_FAST_EN
               dbz       <= zero;
`endif
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifndef DIVZERO_FAST_EN
   assign dbz = 1'b0;
`endif

endmodule
